// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter for the console output path. Characters are
//   queued in a circular FIFO (one per cycle) and serialised LSB first as
//   start / data / [parity] / stop frames. Frames follow each other with no
//   idle gap while the FIFO holds data.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> every frame carries one parity bit (sense set by PARITY_ODD)
//   undefined -> no parity state, DATA goes straight to STOP
//
// Ports
//   sysclk     : single clock, all logic on its rising edge
//   cpu_reset  : synchronous active-high reset (abandons frame, flushes FIFO)
//   wr_en      : write strobe, accepted when the FIFO is not full
//   wr_data    : character to enqueue
//   full       : FIFO holds FIFO_DEPTH entries
//   empty      : FIFO holds no entries
//   level      : current entry count
//   overflow   : one-cycle pulse when a write is dropped because of full
//   busy       : transmitter is not idle
//   uart_tx    : serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          sysclk,
  input  logic                          cpu_reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          uart_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 32'sd1;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = 32'sd3;

  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(CLKS_PER_BIT - 32'sd1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 32'sd1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 32'sd1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};

  // Reject parameter sets the datapath cannot represent.
  if (DATA_BITS < 32'sd5 || DATA_BITS > 32'sd8 || FIFO_DEPTH < 32'sd2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0 || CLKS_PER_BIT < 32'sd2 ||
      STOP_BITS < 32'sd1 || STOP_BITS > 32'sd2 ||
      PARITY_ODD < 32'sd0 || PARITY_ODD > 32'sd1) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD[0];
  endfunction
`endif

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]     level_r, level_s;
  logic                 full_r, empty_r, overflow_r, busy_r, tx_r;
  state_t               state_r, state_s;
  logic [TMR_W-1:0]     timer_r, timer_s;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 push_s, pop_s, tx_s;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r, parity_s;
`endif

  assign push_s = wr_en && !full_r;
  assign head_s = mem_r[rd_ptr_r];

  // Next entry count from this cycle's push/pop pair.
  always_comb begin
    level_s = level_r;
    if (push_s && !pop_s) begin
      level_s = level_r + 1'b1;
    end else if (pop_s && !push_s) begin
      level_s = level_r - 1'b1;
    end else begin
      level_s = level_r;
    end
  end

  // Transmit FSM next state; a pop loads the head character and restarts the bit timer.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s  = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_r) begin
          pop_s     = 1'b1;
          shift_s   = head_s;
          bit_cnt_s = {CNT_W{1'b0}};
          timer_s   = TMR_LOAD;
          state_s   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_s  = calc_parity(head_s);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == TMR_ZERO) begin
          timer_s = TMR_LOAD;
          state_s = ST_DATA;
        end else begin
          timer_s = timer_r - 1'b1;
        end
      end
      ST_DATA: begin
        if (timer_r == TMR_ZERO) begin
          timer_s = TMR_LOAD;
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_s = {CNT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
            state_s   = ST_PARITY;
`else
            state_s   = ST_STOP;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
          end
        end else begin
          timer_s = timer_r - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (timer_r == TMR_ZERO) begin
          timer_s   = TMR_LOAD;
          bit_cnt_s = {CNT_W{1'b0}};
          state_s   = ST_STOP;
        end else begin
          timer_s = timer_r - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (timer_r == TMR_ZERO) begin
          timer_s = TMR_LOAD;
          if (bit_cnt_r != STOP_LAST) begin
            bit_cnt_s = bit_cnt_r + 1'b1;
          end else if (!empty_r) begin
            // Chain the next frame straight out of the last stop cycle.
            pop_s     = 1'b1;
            shift_s   = head_s;
            bit_cnt_s = {CNT_W{1'b0}};
            state_s   = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_s  = calc_parity(head_s);
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          timer_s = timer_r - 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the state being entered, so uart_tx can be registered.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      ST_IDLE:   tx_s = 1'b1;
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_s = parity_s;
`endif
      ST_STOP:   tx_s = 1'b1;
      default:   tx_s = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge sysclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, counters, FSM registers and registered outputs.
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= LVL_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      tx_r       <= 1'b1;
      state_r    <= ST_IDLE;
      timer_r    <= TMR_ZERO;
      bit_cnt_r  <= {CNT_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      level_r    <= level_s;
      full_r     <= (level_s == LVL_FULL);
      empty_r    <= (level_s == LVL_ZERO);
      overflow_r <= wr_en && full_r;
      busy_r     <= (state_s != ST_IDLE);
      tx_r       <= tx_s;
      state_r    <= state_s;
      timer_r    <= timer_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_s;
`endif
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign level    = level_r;
  assign overflow = overflow_r;
  assign busy     = busy_r;
  assign uart_tx  = tx_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. dut1: 8 data bits, depth 4, 4 clocks/bit,
//   1 stop bit, even parity sense. dut2: same but 2 stop bits, odd sense.
//   Frames expected by the stimulus are queued; per-DUT monitors decode the
//   serial line cycle by cycle and compare against the queued characters.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FL1 = (1 + 8 + PBITS + 1) * CLKS;
  localparam int FL2 = (1 + 8 + PBITS + 2) * CLKS;

  logic       sysclk;
  logic       cpu_reset;
  logic       wr_en1, wr_en2;
  logic [7:0] wr_data1, wr_data2;
  logic       full1, empty1, overflow1, busy1, tx1;
  logic       full2, empty2, overflow2, busy2, tx2;
  logic [2:0] level1, level2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp1_q[$];
  logic [7:0] exp2_q[$];
  int         start1_q[$];
  int         start2_q[$];
  int         m1_cnt = -1;
  int         m2_cnt = -1;
  int         m1_frames = 0;

  uart_tx_fifo #(
    .DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CLKS), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut1 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .wr_en(wr_en1), .wr_data(wr_data1),
    .full(full1), .empty(empty1), .level(level1), .overflow(overflow1),
    .busy(busy1), .uart_tx(tx1)
  );

  uart_tx_fifo #(
    .DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CLKS), .STOP_BITS(2), .PARITY_ODD(1)
  ) dut2 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .level(level2), .overflow(overflow2),
    .busy(busy2), .uart_tx(tx2)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  always @(posedge sysclk) cyc <= cyc + 1;

  // Expected line value for bit slot 'slot' of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int slot, input logic odd);
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return d[slot-1];
    else if (PBITS == 1 && slot == 9) return (^d) ^ odd;
    else return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp1_q.size() == 0 && exp2_q.size() == 0 && m1_cnt < 0 && m2_cnt < 0)) begin
      step();
      k++;
    end
    check("drain_timeout", 32'(k >= budget), 32'd0);
  endtask

  task automatic wait_level_not(input logic [2:0] v, input int budget, output logic [2:0] got);
    int k;
    k = 0;
    @(negedge sysclk);
    while (level1 === v && k < budget) begin
      @(negedge sysclk);
      k++;
    end
    got = level1;
  endtask

  // Monitor for dut1: decodes each frame and compares with the queue head.
  initial begin : mon1
    logic [7:0] b;
    logic       unexp, bad, got_v;
    int         bad_at;
    b = 8'h00; unexp = 1'b0; bad = 1'b0; got_v = 1'b0; bad_at = 0;
    forever begin
      @(negedge sysclk);
      if (cpu_reset === 1'b1) begin
        m1_cnt = -1;
        exp1_q.delete();
      end else begin
        if (m1_cnt < 0 && tx1 === 1'b0) begin
          m1_cnt = 0;
          bad = 1'b0;
          start1_q.push_back(cyc);
          if (exp1_q.size() == 0) begin
            unexp = 1'b1;
            n_tests++;
            n_fail++;
            $display("FAIL frame1_unexpected: start bit at cycle %0d, required idle line", cyc);
          end else begin
            unexp = 1'b0;
            b = exp1_q.pop_front();
          end
        end
        if (m1_cnt >= 0) begin
          if (!unexp && !bad && tx1 !== frame_bit(b, m1_cnt / CLKS, 1'b0)) begin
            bad = 1'b1; bad_at = m1_cnt; got_v = tx1;
          end
          if (m1_cnt == FL1 - 1) begin
            m1_cnt = -1;
            m1_frames++;
            if (!unexp) begin
              n_tests++;
              if (bad) begin
                n_fail++;
                $display("FAIL frame1 %02h: line %b at frame cycle %0d, required %b",
                         b, got_v, bad_at, frame_bit(b, bad_at / CLKS, 1'b0));
              end
            end
          end else begin
            m1_cnt++;
          end
        end
      end
    end
  end

  // Monitor for dut2 (two stop bits, odd parity sense).
  initial begin : mon2
    logic [7:0] b;
    logic       unexp, bad, got_v;
    int         bad_at;
    b = 8'h00; unexp = 1'b0; bad = 1'b0; got_v = 1'b0; bad_at = 0;
    forever begin
      @(negedge sysclk);
      if (cpu_reset === 1'b1) begin
        m2_cnt = -1;
        exp2_q.delete();
      end else begin
        if (m2_cnt < 0 && tx2 === 1'b0) begin
          m2_cnt = 0;
          bad = 1'b0;
          start2_q.push_back(cyc);
          if (exp2_q.size() == 0) begin
            unexp = 1'b1;
            n_tests++;
            n_fail++;
            $display("FAIL frame2_unexpected: start bit at cycle %0d, required idle line", cyc);
          end else begin
            unexp = 1'b0;
            b = exp2_q.pop_front();
          end
        end
        if (m2_cnt >= 0) begin
          if (!unexp && !bad && tx2 !== frame_bit(b, m2_cnt / CLKS, 1'b1)) begin
            bad = 1'b1; bad_at = m2_cnt; got_v = tx2;
          end
          if (m2_cnt == FL2 - 1) begin
            m2_cnt = -1;
            if (!unexp) begin
              n_tests++;
              if (bad) begin
                n_fail++;
                $display("FAIL frame2 %02h: line %b at frame cycle %0d, required %b",
                         b, got_v, bad_at, frame_bit(b, bad_at / CLKS, 1'b1));
              end
            end
          end else begin
            m2_cnt++;
          end
        end
      end
    end
  end

  initial begin : main
    logic [7:0] ov_data [6];
    logic [2:0] ov_level [6];
    logic       ov_full [6];
    logic       ov_ovf [6];
    logic [2:0] lv;
    int         k;
    int         frames0;

    ov_data  = '{8'h01, 8'h80, 8'hFE, 8'h7F, 8'hC3, 8'h5A};
    ov_level = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    ov_full  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ov_ovf   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    cpu_reset = 1'b1;
    wr_en1 = 1'b0; wr_data1 = 8'h00;
    wr_en2 = 1'b0; wr_data2 = 8'h00;
    repeat (3) step();
    cpu_reset = 1'b0;

    // Reset values
    @(negedge sysclk);
    check("rst_tx", 32'(tx1), 32'd1);
    check("rst_full", 32'(full1), 32'd0);
    check("rst_empty", 32'(empty1), 32'd1);
    check("rst_level", 32'(level1), 32'd0);
    check("rst_overflow", 32'(overflow1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_tx2", 32'(tx2), 32'd1);
    step();

    // Single byte 0x55: start bit two edges after the write, busy for one frame
    wr_en1 = 1'b1; wr_data1 = 8'h55; exp1_q.push_back(8'h55);
    step();
    wr_en1 = 1'b0;
    @(negedge sysclk);
    check("single_empty_after_wr", 32'(empty1), 32'd0);
    check("single_level_after_wr", 32'(level1), 32'd1);
    check("single_tx_still_idle", 32'(tx1), 32'd1);
    check("single_busy_before_pop", 32'(busy1), 32'd0);
    step();
    @(negedge sysclk);
    check("single_tx_start", 32'(tx1), 32'd0);
    check("single_busy_after_pop", 32'(busy1), 32'd1);
    check("single_level_after_pop", 32'(level1), 32'd0);
    k = 0;
    while (busy1 === 1'b1 && k < 200) begin
      step();
      @(negedge sysclk);
      k++;
    end
    check("single_busy_cycles", 32'(k), 32'(FL1));
    check("single_tx_idle_after", 32'(tx1), 32'd1);
    drain(4 * FL1);

    // Back-to-back: lead byte in flight, then 0xA3 and 0x0F on consecutive cycles
    start1_q.delete();
    wr_en1 = 1'b1; wr_data1 = 8'h3C; exp1_q.push_back(8'h3C);
    step();
    wr_en1 = 1'b0;
    step();
    step();
    wr_en1 = 1'b1; wr_data1 = 8'hA3; exp1_q.push_back(8'hA3);
    step();
    @(negedge sysclk);
    check("b2b_level_1", 32'(level1), 32'd1);
    wr_data1 = 8'h0F; exp1_q.push_back(8'h0F);
    step();
    wr_en1 = 1'b0;
    @(negedge sysclk);
    check("b2b_level_2", 32'(level1), 32'd2);
    wait_level_not(3'd2, 2 * FL1 + 20, lv);
    check("b2b_level_3", 32'(lv), 32'd1);
    wait_level_not(3'd1, 2 * FL1 + 20, lv);
    check("b2b_level_4", 32'(lv), 32'd0);
    drain(4 * FL1);
    check("b2b_frame_count", 32'(start1_q.size()), 32'd3);
    if (start1_q.size() == 3) begin
      check("b2b_gap_1", 32'(start1_q[1] - start1_q[0]), 32'(FL1));
      check("b2b_gap_2", 32'(start1_q[2] - start1_q[1]), 32'(FL1));
    end

    // Write coinciding with the STOP->START pop while level is 1
    start1_q.delete();
    wr_en1 = 1'b1; wr_data1 = 8'h07; exp1_q.push_back(8'h07);
    step();
    wr_en1 = 1'b0;
    step();
    wr_en1 = 1'b1; wr_data1 = 8'h42; exp1_q.push_back(8'h42);
    step();
    wr_en1 = 1'b0;
    repeat (FL1 - 2) step();
    wr_en1 = 1'b1; wr_data1 = 8'hE7; exp1_q.push_back(8'hE7);
    step();
    wr_en1 = 1'b0;
    @(negedge sysclk);
    check("simul_level", 32'(level1), 32'd1);
    check("simul_tx_start", 32'(tx1), 32'd0);
    drain(4 * FL1);
    check("simul_frame_count", 32'(start1_q.size()), 32'd3);
    if (start1_q.size() == 3) begin
      check("simul_gap_1", 32'(start1_q[1] - start1_q[0]), 32'(FL1));
      check("simul_gap_2", 32'(start1_q[2] - start1_q[1]), 32'(FL1));
    end

    // Overflow: six consecutive writes into a depth-4 FIFO
    frames0 = m1_frames;
    for (int i = 0; i < 6; i++) begin
      wr_en1 = 1'b1; wr_data1 = ov_data[i];
      if (i < 5) exp1_q.push_back(ov_data[i]);
      step();
      @(negedge sysclk);
      check($sformatf("ovf_level_%0d", i), 32'(level1), 32'(ov_level[i]));
      check($sformatf("ovf_full_%0d", i), 32'(full1), 32'(ov_full[i]));
      check($sformatf("ovf_pulse_%0d", i), 32'(overflow1), 32'(ov_ovf[i]));
    end
    wr_en1 = 1'b0;
    step();
    @(negedge sysclk);
    check("ovf_pulse_end", 32'(overflow1), 32'd0);
    step();
    drain(8 * FL1);
    repeat (2 * FL1) step();
    check("ovf_frames", 32'(m1_frames - frames0), 32'd5);
    check("ovf_empty_end", 32'(empty1), 32'd1);

    // Reset during data bit 3 of 0xC6 with 0x99 still queued
    wr_en1 = 1'b1; wr_data1 = 8'hC6; exp1_q.push_back(8'hC6);
    step();
    wr_en1 = 1'b0;
    step();
    wr_en1 = 1'b1; wr_data1 = 8'h99; exp1_q.push_back(8'h99);
    step();
    wr_en1 = 1'b0;
    repeat (15) step();
    @(negedge sysclk);
    check("rst_mid_tx_low_bit3", 32'(tx1), 32'd0);
    step();
    cpu_reset = 1'b1;
    step();
    cpu_reset = 1'b0;
    @(negedge sysclk);
    check("rst_mid_tx", 32'(tx1), 32'd1);
    check("rst_mid_level", 32'(level1), 32'd0);
    check("rst_mid_busy", 32'(busy1), 32'd0);
    check("rst_mid_empty", 32'(empty1), 32'd1);
    frames0 = m1_frames;
    repeat (3 * FL1) step();
    check("rst_mid_silent", 32'(m1_frames - frames0), 32'd0);
    wr_en1 = 1'b1; wr_data1 = 8'h3E; exp1_q.push_back(8'h3E);
    step();
    wr_en1 = 1'b0;
    drain(4 * FL1);

    // dut2: two stop bits, odd parity sense, back-to-back frames
    start2_q.delete();
    wr_en2 = 1'b1; wr_data2 = 8'h07; exp2_q.push_back(8'h07);
    step();
    wr_data2 = 8'hB4; exp2_q.push_back(8'hB4);
    step();
    wr_en2 = 1'b0;
    drain(4 * FL2);
    check("stop2_frame_count", 32'(start2_q.size()), 32'd2);
    if (start2_q.size() == 2) begin
      check("stop2_gap", 32'(start2_q[1] - start2_q[0]), 32'(FL2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the core's console output path, placed between the memory-access stage's UART store port and the `uart_tx` pin. Accepts one character per cycle into a FIFO and serialises the characters as 8N1-style frames, LSB first. The frame shape is configurable: data width, stop bits, optional parity. A full-FIFO status lets software or the pipeline throttle instead of silently losing bytes. Back-to-back frames are sent with no idle gap.

## Interface
Parameters:
- `DATA_BITS`, 8: character width; legal range 5..8.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, at least 2.
- `CLKS_PER_BIT`, 868: `sysclk` cycles per serial bit (100 MHz / 115200); at least 2.
- `STOP_BITS`, 1: 1 or 2.
- `PARITY_ODD`, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.

Ports:
- `sysclk` in 1: single clock; all logic is on its rising edge.
- `cpu_reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe, sampled each edge.
- `wr_data` in `DATA_BITS`: character to enqueue.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `level` out `$clog2(FIFO_DEPTH)+1`: current entry count.
- `overflow` out 1: one-cycle pulse when a write is dropped.
- `busy` out 1: FSM not in IDLE.
- `uart_tx` out 1: serial line; idle high.

## Operation
- FIFO: circular buffer with read and write pointers of `$clog2(FIFO_DEPTH)` bits each; pointers wrap modulo `FIFO_DEPTH`; `level` is a separate counter.
- Write acceptance:
  - A write is accepted iff `wr_en && !full` at the edge.
  - If `full`, the write is dropped and `overflow` pulses, even if a pop happens at the same edge.
- Simultaneous write and pop: `level` stays the same; both pointers advance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `uart_tx` = 1. If `!empty`, pop the head into the shift register, clear the bit counter, and go to START.
- START: `uart_tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `uart_tx` = `shift[0]`, held for `CLKS_PER_BIT` cycles per bit. Shift right after each bit.
  - After `DATA_BITS` bits, go to PARITY if parity is compiled in, otherwise to STOP.
- PARITY: `uart_tx` = XOR of the `DATA_BITS` data bits, XOR `PARITY_ODD`, for one bit time. Then go to STOP.
- STOP: `uart_tx` = 1 for `STOP_BITS × CLKS_PER_BIT` cycles. On the final cycle:
  - if `!empty`, pop and go directly to START (no gap);
  - otherwise go to IDLE.
- Bit timer: counts down from `CLKS_PER_BIT-1` to 0. The state or bit changes on the edge where the count is 0.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and `uart_tx` returns high on the next edge.

## Timing
- Reset values:
  - `uart_tx` = 1, `full` = 0, `empty` = 1, `level` = 0, `overflow` = 0, `busy` = 0.
  - FSM = IDLE; pointers, counters and timer = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: a write sampled at edge E0 into an empty FIFO with the FSM idle makes `empty` = 0 after E0. The pop happens at E1, and `uart_tx` falls after E1.
- Frame length: `(1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT` cycles, where P = 1 with parity and 0 without.
- Throughput: continuous frames while the FIFO is non-empty.
- `full` and `empty` update on the same edge as the write or pop that changes them.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state exists and every frame carries one parity bit whose sense follows `PARITY_ODD`.
- Undefined: the PARITY state and parity logic are removed, DATA goes directly to STOP, and `PARITY_ODD` is ignored.

## Test plan
- Single byte, with `CLKS_PER_BIT` = 4, `DATA_BITS` = 8, `STOP_BITS` = 1, no parity: write 0x55 → `uart_tx` falls 2 edges after the write and shows 0,1,0,1,0,1,0,1,0,1, each bit lasting 4 cycles. The line then idles high, and `busy` drops after 40 cycles of frame.
- Back-to-back: write 0xA3 and 0x0F on consecutive cycles → two frames with no idle cycle between the stop bit and the second start bit; `level` goes 1, 2, 1, 0.
- Overflow with `FIFO_DEPTH` = 4: write 6 bytes while the FSM holds the first frame → the first pops, then 4 are buffered; the 6th asserts `overflow` for one cycle and raises `full`. Only 5 frames are transmitted.
- Simultaneous write and pop at the STOP→START edge with `level` = 1 → `level` stays 1 and the data order is preserved.
- Parity (macro defined), even: byte 0x07 → parity bit 1. With `PARITY_ODD` = 1 → parity bit 0. `STOP_BITS` = 2 → the line stays high for 8 cycles.
- Reset mid-DATA: assert `cpu_reset` during bit 3 → next edge `uart_tx` = 1, `level` = 0, `busy` = 0. Nothing is transmitted afterwards until a new write.
